// File: rtl/board_input_ctrl.sv
// board_input_ctrl: Avalon-MM slave exposing the board pushbuttons and slide
// switches. Each pin is synchronised and debounced; key presses and switch
// changes are latched as write-1-to-clear edge flags that can raise a
// maskable level interrupt.
module board_input_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_SW-1:0]   sw_in,
  input  logic                avs_chipselect,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_SW-1:0]   sw_state
);

  // Keys occupy the low bits of the combined input vector, switches the high bits.
  localparam int N  = NUM_KEYS + NUM_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0]  INV_MASK = (KEY_ACTIVE_LOW != 0) ?
                                       {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}} : {N{1'b0}};
  localparam logic [31:0]   ID_WORD  = {8'hB1, 8'(NUM_SW), 8'(NUM_KEYS), 8'h01};

  localparam logic [2:0] A_KEY_STATE = 3'd0;
  localparam logic [2:0] A_SW_STATE  = 3'd1;
  localparam logic [2:0] A_KEY_EDGE  = 3'd2;
  localparam logic [2:0] A_SW_EDGE   = 3'd3;
  localparam logic [2:0] A_KEY_MASK  = 3'd4;
  localparam logic [2:0] A_SW_MASK   = 3'd5;
  localparam logic [2:0] A_ID        = 3'd6;

  logic [N-1:0]        sync_q [SYNC_STAGES];
  logic [N-1:0]        synced;
  logic [N-1:0]        stable_q, stable_d;
  logic [CW-1:0]       cnt_q [N];
  logic [CW-1:0]       cnt_d [N];

  logic [NUM_KEYS-1:0] key_rise, key_clr, key_edge_q, key_edge_d, key_mask_q, key_mask_d;
  logic [NUM_SW-1:0]   sw_chg, sw_clr, sw_edge_q, sw_edge_d, sw_mask_q, sw_mask_d;
  logic                wr_en, rd_en;
  logic [31:0]         rd_mux, readdata_q;
  logic                irq_q;

  // Only the low bits of the write data land in registers.
  logic                unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Synchroniser chain for every raw pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {sw_in, key_in};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Keys become 1 = pressed after this polarity fix.
  assign synced = sync_q[SYNC_STAGES-1] ^ INV_MASK;

  // Per-bit debounce: count consecutive mismatching cycles, adopt the synced value on the last one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = synced[i];
        else                      cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_state = stable_q[NUM_KEYS-1:0];
  assign sw_state  = stable_q[N-1:NUM_KEYS];

  // Edge flags are set on the same edge the debounced value changes.
  assign key_rise = stable_d[NUM_KEYS-1:0] & ~stable_q[NUM_KEYS-1:0];
  assign sw_chg   = stable_d[N-1:NUM_KEYS] ^  stable_q[N-1:NUM_KEYS];

  assign wr_en = avs_chipselect & avs_write;
  assign rd_en = avs_chipselect & avs_read;

  // Write decode; a new edge wins over a simultaneous clear.
  always_comb begin
    key_clr    = '0;
    sw_clr     = '0;
    key_mask_d = key_mask_q;
    sw_mask_d  = sw_mask_q;
    if (wr_en) begin
      case (avs_address)
        A_KEY_EDGE: key_clr    = avs_writedata[NUM_KEYS-1:0];
        A_SW_EDGE:  sw_clr     = avs_writedata[NUM_SW-1:0];
        A_KEY_MASK: key_mask_d = avs_writedata[NUM_KEYS-1:0];
        A_SW_MASK:  sw_mask_d  = avs_writedata[NUM_SW-1:0];
        default: ;
      endcase
    end
    key_edge_d = (key_edge_q & ~key_clr) | key_rise;
    sw_edge_d  = (sw_edge_q  & ~sw_clr)  | sw_chg;
  end

  // Edge flag and mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_edge_q <= '0;
      sw_edge_q  <= '0;
      key_mask_q <= '0;
      sw_mask_q  <= '0;
    end else begin
      key_edge_q <= key_edge_d;
      sw_edge_q  <= sw_edge_d;
      key_mask_q <= key_mask_d;
      sw_mask_q  <= sw_mask_d;
    end
  end

  // Read mux over current register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_KEY_STATE: rd_mux = 32'(stable_q[NUM_KEYS-1:0]);
      A_SW_STATE:  rd_mux = 32'(stable_q[N-1:NUM_KEYS]);
      A_KEY_EDGE:  rd_mux = 32'(key_edge_q);
      A_SW_EDGE:   rd_mux = 32'(sw_edge_q);
      A_KEY_MASK:  rd_mux = 32'(key_mask_q);
      A_SW_MASK:   rd_mux = 32'(sw_mask_q);
      A_ID:        rd_mux = ID_WORD;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data (holds between reads) and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (rd_en) readdata_q <= rd_mux;
      irq_q <= (|(key_edge_q & key_mask_q)) | (|(sw_edge_q & sw_mask_q));
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a window-based model.
module tb_board_input_ctrl;

  localparam int K = 4;
  localparam int W = 10;
  localparam int D = 8;
  localparam int S = 2;
  localparam int N = K + W;
  localparam logic [N-1:0] POL = {{W{1'b0}}, {K{1'b1}}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [K-1:0]  key_in = '1;
  logic [W-1:0]  sw_in = '0;
  logic          avs_chipselect = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [K-1:0]  key_state;
  logic [W-1:0]  sw_state;

  int checks = 0;
  int failures = 0;

  board_input_ctrl #(
    .NUM_KEYS(K), .NUM_SW(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .sw_in(sw_in),
    .avs_chipselect(avs_chipselect), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .key_state(key_state), .sw_state(sw_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A debounced bit flips when the synced value has disagreed with it on each
  // of the last D cycles. Synced value = pin as sampled S edges earlier.
  logic [K-1:0]  m_kstate = '0, m_kedge = '0, m_kmask = '0;
  logic [W-1:0]  m_sstate = '0, m_sedge = '0, m_smask = '0;
  logic          m_irq = 1'b0;
  logic [31:0]   m_rd = '0;
  logic [N-1:0]  m_pipe [S];
  logic [N-1:0]  m_hist [D-1];
  int            m_hcnt = 0;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_kstate);
      3'd1: return 32'(m_sstate);
      3'd2: return 32'(m_kedge);
      3'd3: return 32'(m_sedge);
      3'd4: return 32'(m_kmask);
      3'd5: return 32'(m_smask);
      3'd6: return {8'hB1, 8'(W), 8'(K), 8'h01};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [N-1:0] syn, stab, nstab, mis;
    logic [K-1:0] kclr;
    logic [W-1:0] sclr;
    if (reset) begin
      m_kstate <= '0; m_kedge <= '0; m_kmask <= '0;
      m_sstate <= '0; m_sedge <= '0; m_smask <= '0;
      m_irq <= 1'b0; m_rd <= '0; m_hcnt <= 0;
      for (int i = 0; i < S; i++) m_pipe[i] <= '0;
      for (int i = 0; i < D-1; i++) m_hist[i] <= '0;
    end else begin
      syn  = m_pipe[S-1] ^ POL;
      stab = {m_sstate, m_kstate};
      mis  = syn ^ stab;
      for (int i = 0; i < D-1; i++) mis = mis & (m_hist[i] ^ stab);
      if (m_hcnt < D-1) mis = '0;
      nstab = stab ^ mis;
      kclr = '0; sclr = '0;
      if (avs_chipselect && avs_write) begin
        if (avs_address == 3'd2) kclr = avs_writedata[K-1:0];
        if (avs_address == 3'd3) sclr = avs_writedata[W-1:0];
        if (avs_address == 3'd4) m_kmask <= avs_writedata[K-1:0];
        if (avs_address == 3'd5) m_smask <= avs_writedata[W-1:0];
      end
      if (avs_chipselect && avs_read) m_rd <= m_read(avs_address);
      m_irq    <= (|(m_kedge & m_kmask)) || (|(m_sedge & m_smask));
      m_kedge  <= (m_kedge & ~kclr) | (nstab[K-1:0] & ~stab[K-1:0]);
      m_sedge  <= (m_sedge & ~sclr) | (nstab[N-1:K] ^ stab[N-1:K]);
      m_kstate <= nstab[K-1:0];
      m_sstate <= nstab[N-1:K];
      m_hist[0] <= syn;
      for (int i = 1; i < D-1; i++) m_hist[i] <= m_hist[i-1];
      if (m_hcnt < D-1) m_hcnt <= m_hcnt + 1;
      m_pipe[0] <= {sw_in, key_in};
      for (int i = 1; i < S; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_key_state", 32'(key_state), 32'(m_kstate));
    check("cmp_sw_state",  32'(sw_state),  32'(m_sstate));
    check("cmp_irq",       32'(irq),       32'(m_irq));
    check("cmp_readdata",  avs_readdata,   m_rd);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    cyc();
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = v;
    cyc();
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int first;

    // 1. reset values and ID
    cyc(3);
    reset = 1'b0;
    cyc(15);
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_sw_state",  32'(sw_state),  32'h0);
    check("rst_irq",       32'(irq),       32'h0);
    check("rst_readdata",  avs_readdata,   32'h0);
    bus_read(3'd6, d);
    check("id_read", d, 32'hB10A0401);
    check("model_id", m_rd, 32'hB10A0401);

    // 2. key0 press latency = S + D
    key_in[0] = 1'b0;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (first < 0 && key_state[0]) first = n;
    end
    check("key0_latency", 32'(first), 32'd10);
    bus_read(3'd2, d);
    check("key_edge_after_press", d, 32'h1);
    check("model_kedge", 32'(m_kedge), 32'h1);
    check("irq_masked", 32'(irq), 32'h0);
    key_in[0] = 1'b1;
    cyc(12);

    // 3. bouncing key1 never passes the filter
    for (int t = 0; t < 10; t++) begin
      key_in[1] = ~key_in[1];
      cyc(3);
    end
    key_in[1] = 1'b1;
    cyc(12);
    check("bounce_key_state", 32'(key_state), 32'h0);
    bus_read(3'd2, d);
    check("bounce_key_edge", d, 32'h1);

    // 4. masked interrupt on key0
    bus_write(3'd2, 32'h1);
    bus_write(3'd4, 32'h1);
    cyc(2);
    check("irq_idle", 32'(irq), 32'h0);
    key_in[0] = 1'b0;
    first = -1;
    for (int n = 1; n <= 15; n++) begin
      cyc();
      if (first < 0 && irq) first = n;
    end
    check("irq_latency", 32'(first), 32'd11);
    bus_write(3'd2, 32'h1);
    check("irq_hold_after_clr", 32'(irq), 32'h1);
    cyc();
    check("irq_drop_after_clr", 32'(irq), 32'h0);
    key_in[0] = 1'b1;
    cyc(12);

    // 5. clear coinciding with key2 edge: set wins
    key_in[2] = 1'b0;
    cyc(9);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 3'd2; avs_writedata = 32'h4;
    cyc();
    avs_chipselect = 1'b0; avs_write = 1'b0;
    check("key2_state", 32'(key_state), 32'h4);
    bus_read(3'd2, d);
    check("set_beats_clear", d, 32'h4);
    key_in[2] = 1'b1;
    cyc(12);
    bus_write(3'd2, 32'hF);

    // 6. reset mid-debounce restarts the full latency
    sw_in[3] = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(2);
    check("sw_state_in_reset", 32'(sw_state), 32'h0);
    reset = 1'b0;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (first < 0 && sw_state[3]) first = n;
    end
    check("sw3_latency_after_reset", 32'(first), 32'd10);
    bus_read(3'd3, d);
    check("sw_edge_after_reset", d, 32'h8);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) key_in = K'($urandom);
      if ($urandom_range(0, 15) == 0) sw_in  = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        avs_chipselect = ($urandom_range(0, 4) != 0);
        avs_read       = 1'($urandom);
        avs_write      = 1'($urandom);
        avs_address    = 3'($urandom);
        avs_writedata  = $urandom;
      end else begin
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 3));
        reset = 1'b0;
      end
      cyc();
    end
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
